// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, tracks reads through a MEM_LAT tag pipe, buffers words for decode.
// Issue-to-if_valid latency is MEM_LAT cycles; issue stalls unless in-flight + buffered < FIFO_DEPTH.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + MEM_LAT) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic           epoch_q;
    logic [31:0]    fifo_instr_q [FIFO_DEPTH];
    logic [31:0]    fifo_pc_q    [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW:0]    cnt_q;

    logic           issue;
    logic           ret_vld;
    logic [31:0]    ret_pc;
    logic           ret_epoch;
    logic [CW-1:0]  inflight;
    logic           pipe_busy;
    logic           enq;
    logic           deq;

    assign imem_addr = pc_q;
    assign if_valid  = (cnt_q != '0);
    assign if_instr  = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign deq       = if_valid & if_ready;
    assign issue     = (state_q == RUN) && !redirect_i &&
                       ((inflight + CW'(cnt_q)) < CW'(FIFO_DEPTH));
    assign enq       = ret_vld && (ret_epoch == epoch_q) && !redirect_i;
    assign busy      = issue | pipe_busy | (cnt_q != '0);

    // With MEM_LAT = 1 the memory answers in the issue cycle, so the tag never needs a register.
    if (MEM_LAT == 1) begin : g_comb
        assign ret_vld   = issue;
        assign ret_pc    = pc_q;
        assign ret_epoch = epoch_q;
        assign inflight  = '0;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        localparam int NS = MEM_LAT - 1;
        logic [NS-1:0] vld_q;
        logic [31:0]   tpc_q [NS];
        logic [NS-1:0] tep_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                tep_q <= '0;
                for (int i = 0; i < NS; i++) tpc_q[i] <= 32'h0;
            end else begin
                vld_q[0] <= issue;
                tpc_q[0] <= pc_q;
                tep_q[0] <= epoch_q;
                // Killing stale tags on redirect keeps back-to-back redirects from aliasing the 1-bit epoch.
                for (int i = 1; i < NS; i++) begin
                    vld_q[i] <= vld_q[i-1] & ~redirect_i;
                    tpc_q[i] <= tpc_q[i-1];
                    tep_q[i] <= tep_q[i-1];
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < NS; i++) inflight = inflight + CW'(vld_q[i]);
        end

        assign ret_vld   = vld_q[NS-1];
        assign ret_pc    = tpc_q[NS-1];
        assign ret_epoch = tep_q[NS-1];
        assign pipe_busy = |vld_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            epoch_q  <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= 32'h0;
                fifo_pc_q[i]    <= 32'h0;
            end
        end else begin
            case (state_q)
                IDLE:    if (fetch_en)  state_q <= RUN;
                RUN:     if (!fetch_en) state_q <= IDLE;
                default:                state_q <= IDLE;
            endcase

            if (redirect_i) begin
                pc_q    <= {redirect_pc[31:2], 2'b00};
                epoch_q <= ~epoch_q;
            end else if (issue) begin
                pc_q    <= pc_q + 32'd4;
            end

            if (enq) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata;
                fifo_pc_q[wr_ptr_q]    <= ret_pc;
            end

            // A transfer in the redirect cycle still completes; everything behind it is flushed.
            if (redirect_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(deq);
                wr_ptr_q <= rd_ptr_q + PW'(deq);
                cnt_q    <= '0;
            end else begin
                if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
                cnt_q <= cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !deq && (cnt_q == (PW+1)'(FIFO_DEPTH))))
        else $error("imem_fetch_ctrl: output FIFO overflow");

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (MEM_LAT 1 and 3) share stimulus; each delivered
// stream is compared with an in-order PC model and a hashed memory image.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int ML0 = 1;
    localparam int ML1 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_i;
    logic [31:0] redirect_pc;
    logic        if_ready;

    logic [31:0] addr  [2];
    logic [31:0] rdata [2];
    logic [31:0] instr [2];
    logic [31:0] pcv   [2];
    logic        vld   [2];
    logic        bsy   [2];

    int checks   = 0;
    int failures = 0;
    int xfers [2] = '{0, 0};
    logic saw_zero [2];
    logic [31:0] exp_pc [2];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.RESET_PC(RPC), .MEM_LAT(ML0), .FIFO_DEPTH(2)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(addr[0]),
        .imem_rdata(rdata[0]), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .if_valid(vld[0]), .if_ready(if_ready), .if_instr(instr[0]), .if_pc(pcv[0]),
        .busy(bsy[0])
    );

    imem_fetch_ctrl #(.RESET_PC(RPC), .MEM_LAT(ML1), .FIFO_DEPTH(2)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(addr[1]),
        .imem_rdata(rdata[1]), .redirect_i(redirect_i), .redirect_pc(redirect_pc),
        .if_valid(vld[1]), .if_ready(if_ready), .if_instr(instr[1]), .if_pc(pcv[1]),
        .busy(bsy[1])
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int ml_of(input int k);
        return (k == 0) ? ML0 : ML1;
    endfunction

    // Memory images: latency 1 reads the current address, latency 3 the address from two cycles back.
    logic [31:0] h1, h2;
    always_ff @(posedge clk) begin
        h1 <= addr[1];
        h2 <= h1;
    end
    assign rdata[0] = memf(addr[0]);
    assign rdata[1] = memf(h2);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc_go();
        @(posedge clk);
        #1;
    endtask

    // Stream model: every transfer must be the next sequential PC since the last reset/redirect,
    // carrying that address's memory word; a held head must not change.
    initial begin
        logic        hold  [2];
        logic [31:0] hpc   [2];
        logic [31:0] hins  [2];
        hold = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    exp_pc[k] = RPC;
                    hold[k]   = 1'b0;
                end else begin
                    if (hold[k]) begin
                        check_eq("hold_vld",   32'(vld[k]), 32'd1);
                        check_eq("hold_pc",    pcv[k],   hpc[k]);
                        check_eq("hold_instr", instr[k], hins[k]);
                    end
                    if (vld[k] && if_ready) begin
                        check_eq("xfer_pc",    pcv[k],   exp_pc[k]);
                        check_eq("xfer_instr", instr[k], memf(exp_pc[k]));
                        if (pcv[k] == 32'h0) saw_zero[k] = 1'b1;
                        exp_pc[k] = exp_pc[k] + 32'd4;
                        xfers[k]++;
                    end
                    if (redirect_i) exp_pc[k] = {redirect_pc[31:2], 2'b00};
                    hold[k] = vld[k] && !if_ready && !redirect_i;
                    hpc[k]  = pcv[k];
                    hins[k] = instr[k];
                end
            end
        end
    end

    task automatic redir(input logic [31:0] tgt, input logic coin, input int exp_xfer);
        int lat [2];
        int xb  [2];
        lat = '{-1, -1};
        xb  = xfers;
        redirect_i  = 1'b1;
        redirect_pc = tgt;
        if_ready    = coin;
        look();
        for (int k = 0; k < 2; k++)
            check_eq("redir_xfer", 32'(xfers[k] - xb[k]), 32'(exp_xfer));
        cyc_go();
        redirect_i = 1'b0;
        if_ready   = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            look();
            for (int k = 0; k < 2; k++) begin
                if (n == 1) begin
                    check_eq("redir_addr",  addr[k], {tgt[31:2], 2'b00});
                    check_eq("redir_flush", 32'(vld[k]), 32'd0);
                end
                if (vld[k] && lat[k] < 0) begin
                    lat[k] = n;
                    check_eq("redir_pc", pcv[k], {tgt[31:2], 2'b00});
                end
            end
            cyc_go();
        end
        for (int k = 0; k < 2; k++)
            check_eq("redir_lat", 32'(lat[k]), 32'(1 + ml_of(k)));
    endtask

    initial begin
        int fv [2];
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        if_ready    = 1'b1;
        redirect_i  = 1'b0;
        redirect_pc = 32'h0;
        saw_zero    = '{1'b0, 1'b0};
        fv          = '{-1, -1};
        #12;

        // Reset values
        look();
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_addr",  addr[k], RPC);
            check_eq("rst_vld",   32'(vld[k]), 32'd0);
            check_eq("rst_instr", instr[k], 32'h0);
            check_eq("rst_pc",    pcv[k], 32'h0);
            check_eq("rst_busy",  32'(bsy[k]), 32'd0);
        end
        cyc_go();
        rst_n = 1'b1;

        // Free-running fetch: cycle 0 is IDLE, cycle 1 the first RUN cycle
        for (int c = 0; c < 10; c++) begin
            look();
            if (c >= 1 && c <= 4) check_eq("seq_addr", addr[0], RPC + 32'(4 * (c - 1)));
            if (c == 2 || c == 3) check_eq("seq_pc", pcv[0], RPC + 32'(4 * (c - 2)));
            for (int k = 0; k < 2; k++)
                if (vld[k] && fv[k] < 0) fv[k] = c;
            cyc_go();
        end
        for (int k = 0; k < 2; k++) check_eq("first_vld", 32'(fv[k]), 32'(1 + ml_of(k)));

        // Fill under backpressure, then assert reset mid-cycle
        if_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin look(); cyc_go(); end
        look();
        for (int k = 0; k < 2; k++) check_eq("full_vld", 32'(vld[k]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("arst_vld",  32'(vld[k]), 32'd0);
            check_eq("arst_busy", 32'(bsy[k]), 32'd0);
            check_eq("arst_addr", addr[k], RPC);
        end
        look();
        cyc_go();
        rst_n = 1'b1;

        // Backpressure from reset: two words buffered, issue stalls at RPC+8
        for (int c = 0; c < 8; c++) begin look(); cyc_go(); end
        look();
        for (int k = 0; k < 2; k++) begin
            check_eq("bp_vld",   32'(vld[k]), 32'd1);
            check_eq("bp_pc",    pcv[k], RPC);
            check_eq("bp_instr", instr[k], memf(RPC));
            check_eq("bp_busy",  32'(bsy[k]), 32'd1);
            check_eq("bp_addr",  addr[k], RPC + 32'd8);
        end
        cyc_go();
        if_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin look(); cyc_go(); end

        // Redirect with buffered words, unaligned target
        if_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin look(); cyc_go(); end
        redir(32'h0000_2003, 1'b0, 0);

        // Redirect coincident with a handshake
        if_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin look(); cyc_go(); end
        look();
        for (int k = 0; k < 2; k++) check_eq("coin_vld", 32'(vld[k]), 32'd1);
        cyc_go();
        redir(32'h0000_3000, 1'b1, 1);

        // PC wrap
        saw_zero = '{1'b0, 1'b0};
        redir(32'hFFFF_FFF8, 1'b0, 0);
        for (int c = 0; c < 12; c++) begin look(); cyc_go(); end
        for (int k = 0; k < 2; k++) check_eq("wrap_zero", 32'(saw_zero[k]), 32'd1);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            fetch_en    = ($urandom_range(0, 9) != 0);
            if_ready    = ($urandom_range(0, 3) != 0);
            redirect_i  = ($urandom_range(0, 29) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            cyc_go();
        end

        // Drain
        redirect_i = 1'b0;
        fetch_en   = 1'b0;
        if_ready   = 1'b1;
        for (int c = 0; c < 20; c++) begin look(); cyc_go(); end
        look();
        for (int k = 0; k < 2; k++) begin
            check_eq("drain_vld",  32'(vld[k]), 32'd0);
            check_eq("drain_busy", 32'(bsy[k]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
